custom_range_search_unit: RTL and testbench
===========================================

Name: custom_range_search_unit

Overview:
Scans the first num_elems words of the on-chip data RAM and finds the longest contiguous window whose value spread meets a selectable criterion.
- Mode 0: max−min == len−1, i.e. a consecutive run.
- Mode 1: max−min <= threshold.
- Parametrised successor to the fixed 16-bit/512-word counter unit. Adds pipelined one-element-per-cycle reads, configurable read latency, signed/unsigned compare, early termination, and busy/finish handshake.
- Sits on the Nios custom-component bus beside the dual-port RAM; software drives start and reads the results.

Parameters:
- DATA_W, 16, element width.
- ADDR_W, 9, RAM address width (depth 2^ADDR_W).
- RD_LAT, 1, RAM read latency in cycles (legal 1..2).

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  request; accepted only when state is IDLE or DONE
- num_elems  in  ADDR_W+1  element count N, sampled at accept
- mode  in  1  0 = consecutive, 1 = threshold; sampled at accept
- signed_mode  in  1  1 = two's-complement compare; sampled at accept
- threshold  in  DATA_W  mode-1 spread limit, unsigned; sampled at accept
- read_data  in  DATA_W  RAM data, valid RD_LAT cycles after address
- address  out  ADDR_W  RAM read address
- write_enable  out  1  tied 0 (read-only client)
- busy  out  1  high from accept until DONE
- finish  out  1  high in DONE until next accept or reset
- start_pos  out  ADDR_W  first index of best window
- length  out  ADDR_W+1  best window length
- win_min  out  DATA_W  min of best window
- win_max  out  DATA_W  max of best window

Behaviour:
- Reset (resetn low at a clock edge, any state):
  - state = IDLE.
  - All outputs and internal registers = 0.
  - Aborts a scan in progress; no partial results are retained.
- States: IDLE, ROW_INIT, SCAN, DRAIN, NEXT, DONE.
- IDLE/DONE, start = 1:
  - Latch inputs; N = min(num_elems, 2^ADDR_W).
  - Clear best (best_len = 0, start_pos = 0, win_min/max = 0); i = 0; finish = 0; busy = 1.
  - If N = 0, go to DONE next edge (finish 1 cycle after accept, length 0). Otherwise go to ROW_INIT.
- start while busy is ignored.
- ROW_INIT (1 cycle): j = i; clear running min/max valid flag; go to SCAN.
- SCAN:
  - address = j each cycle, j++.
  - After issuing N−1, go to DRAIN. Row i occupies N−i cycles.
- DRAIN: RD_LAT cycles, then NEXT.
- Return pipeline:
  - An RD_LAT-deep tag pipe carries the issued j.
  - When a tag emerges, the returned element updates the running min/max: the first element of a row initialises both; signed or unsigned compare per signed_mode.
  - spread = new_max − new_min, computed in DATA_W+1 bits, always non-negative.
  - Window [i, j] qualifies when:
    - mode 0: spread == j−i;
    - mode 1: spread <= threshold (threshold zero-extended).
  - If the window qualifies and (j−i+1) > best_len (strict, so the earliest window wins a tie), update best_len, start_pos = i, win_min, win_max in the same cycle.
- NEXT (1 cycle): i++. If i+1 >= N or N−(i+1) <= best_len, go to DONE (early termination); else go to ROW_INIT.
- Row cost: (N−i) + RD_LAT + 2 cycles.
- DONE: finish = 1, busy = 0, results stable; length = best_len.
- A single element always qualifies in both modes, so N >= 1 gives length >= 1.
- address holds its last value outside SCAN; it returns to 0 on reset only.

Decomposition:
- Package custom_search_pkg:
  - state enum (state_t);
  - mode enum (SEARCH_CONSEC = 0, SEARCH_THRESH = 1);
  - localparam RD_LAT_MAX = 2.
- One sub-module: custom_window_tracker.
  - Holds running min/max and valid flag.
  - Signed/unsigned compare; spread; qualify output.
  - Parametrised by DATA_W.

Test Plan:
1. RD_LAT=1, mode 0, unsigned, N=6, RAM {5,3,4,9,10,11} -> start_pos 0, length 3, win_min 3, win_max 5. The tie with window {9,10,11} at position 3 resolves earliest.
2. N=4, RAM {0xFFFF,0,1,0xFFFE}, mode 0:
   - signed -> start_pos 0, length 4, min 0xFFFE, max 0x0001;
   - unsigned -> start_pos 1, length 2, min 0, max 1.
3. mode 1, threshold 2, N=7, RAM {10,12,11,20,21,22,23} -> start_pos 0, length 3, min 10, max 12.
4. RD_LAT=1, N=4, RAM {1,2,3,4}, accept at edge 0 -> finish rises at edge 7 (early termination after row 0); length 4, start_pos 0. With RD_LAT=2 -> edge 8.
5. num_elems=0 -> finish 1 cycle after accept, length 0. num_elems=1 -> length 1, start_pos 0. Start pulsed while busy -> no effect on result or timing.
6. resetn low for 1 cycle mid-SCAN -> next cycle all outputs 0, IDLE. A new start then re-runs test 1 with identical results.

Source files
------------

// File: rtl/custom_range_search_unit_pkg.sv
// Shared types for the range search unit: controller states, search modes and
// the read-latency limit supported by the return pipeline.
package custom_search_pkg;

  localparam int RD_LAT_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ROW_INIT = 3'd1,
    ST_SCAN     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  typedef enum logic {
    SEARCH_CONSEC = 1'b0,
    SEARCH_THRESH = 1'b1
  } search_mode_t;

  // Keeps the return pipeline depth inside the range the controller supports.
  function automatic int clamp_lat(input int lat);
    if (lat < 1)          return 1;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/custom_range_search_unit_tracker.sv
// Running min/max of the current window plus the spread test that decides
// whether the window ending at the newest element qualifies.
module custom_window_tracker
  import custom_search_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              update_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              signed_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] threshold_i,
  input  logic [OFF_W-1:0]  offset_i,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic              qualify_o
);

  localparam int CMP_W = (DATA_W + 1 > OFF_W) ? DATA_W + 1 : OFF_W;

  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic              valid_q, valid_d;
  logic [DATA_W:0]   ext_data, ext_min, ext_max, spread;

  // One extra bit (sign copy or zero) lets a single signed comparator and
  // subtractor serve both compare modes.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch.
    min_o     = data_i;
    max_o     = data_i;
    qualify_o = 1'b0;
    ext_data  = {signed_i & data_i[DATA_W-1], data_i};
    ext_min   = {signed_i & min_q[DATA_W-1], min_q};
    ext_max   = {signed_i & max_q[DATA_W-1], max_q};
    if (valid_q) begin
      min_o = ($signed(ext_data) < $signed(ext_min)) ? data_i : min_q;
      max_o = ($signed(ext_data) > $signed(ext_max)) ? data_i : max_q;
    end
    spread = {signed_i & max_o[DATA_W-1], max_o} - {signed_i & min_o[DATA_W-1], min_o};
    if (mode_i == SEARCH_CONSEC) qualify_o = (CMP_W'(spread) == CMP_W'(offset_i));
    else                         qualify_o = (spread <= {1'b0, threshold_i});
  end

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (update_i) begin
      min_d   = min_o;
      max_d   = max_o;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with <= so every register samples pre-edge values.
    if (!rst_n) begin
      min_q   <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/custom_range_search_unit.sv
// Scans the first N RAM words row by row (window start i, end j) and keeps the
// longest window whose spread meets the selected criterion.
module custom_range_search_unit
  import custom_search_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   num_elems,
  input  logic              mode,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable,
  output logic              busy,
  output logic              finish,
  output logic [ADDR_W-1:0] start_pos,
  output logic [ADDR_W:0]   length,
  output logic [DATA_W-1:0] win_min,
  output logic [DATA_W-1:0] win_max
);

  localparam int              LAT     = clamp_lat(RD_LAT);
  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d, i_q, i_d, j_q, j_d, best_len_q, best_len_d;
  search_mode_t        mode_q, mode_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   thresh_q, thresh_d, wmin_q, wmin_d, wmax_q, wmax_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, start_q, start_d;
  logic [1:0]          drain_q, drain_d;
  logic                tag_vld_q [LAT];
  logic [ADDR_W:0]     tag_j_q   [LAT];

  logic                accept, last_issue, drain_last, early_stop, qualify;
  logic [ADDR_W:0]     i_next, offset, win_len;
  logic [DATA_W-1:0]   new_min, new_max;

  assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign i_next     = i_q + CNT_ONE;
  assign last_issue = (j_q == n_q - CNT_ONE);
  assign drain_last = (drain_q == 2'(LAT - 1));
  // Stop once no remaining row can be longer than the best window found.
  assign early_stop = (i_next >= n_q) || ((n_q - i_next) <= best_len_q);
  assign offset     = tag_j_q[LAT-1] - i_q;
  assign win_len    = offset + CNT_ONE;

  custom_window_tracker #(
    .DATA_W (DATA_W),
    .OFF_W  (ADDR_W + 1)
  ) u_tracker (
    .clk         (clock),
    .rst_n       (resetn),
    .clear_i     (state_q == ST_ROW_INIT),
    .update_i    (tag_vld_q[LAT-1]),
    .data_i      (read_data),
    .signed_i    (signed_q),
    .mode_i      (mode_q),
    .threshold_i (thresh_q),
    .offset_i    (offset),
    .min_o       (new_min),
    .max_o       (new_max),
    .qualify_o   (qualify)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_ROW_INIT;
      ST_ROW_INIT:      state_d = (n_q == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN:          if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN:         if (drain_last) state_d = ST_NEXT;
      ST_NEXT:          state_d = early_stop ? ST_DONE : ST_ROW_INIT;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == ST_ROW_INIT) || (state_q == ST_SCAN) ||
                   (state_q == ST_DRAIN)    || (state_q == ST_NEXT);
    finish       = (state_q == ST_DONE);
    address      = (state_q == ST_SCAN) ? j_q[ADDR_W-1:0] : addr_q;
    write_enable = 1'b0;
    start_pos    = start_q;
    length       = best_len_q;
    win_min      = wmin_q;
    win_max      = wmax_q;
  end

  always_comb begin
    n_d        = n_q;
    mode_d     = mode_q;
    signed_d   = signed_q;
    thresh_d   = thresh_q;
    i_d        = i_q;
    j_d        = j_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    best_len_d = best_len_q;
    start_d    = start_q;
    wmin_d     = wmin_q;
    wmax_d     = wmax_q;
    case (state_q)
      ST_ROW_INIT: j_d = i_q;
      ST_SCAN: begin
        addr_d  = j_q[ADDR_W-1:0];
        j_d     = j_q + CNT_ONE;
        drain_d = '0;
      end
      ST_DRAIN: drain_d = drain_q + 2'd1;
      ST_NEXT:  i_d = i_next;
      default: ;
    endcase
    // Strict compare: on equal length the earlier window is kept.
    if (tag_vld_q[LAT-1] && qualify && (win_len > best_len_q)) begin
      best_len_d = win_len;
      start_d    = i_q[ADDR_W-1:0];
      wmin_d     = new_min;
      wmax_d     = new_max;
    end
    if (accept) begin
      n_d        = (num_elems > DEPTH) ? DEPTH : num_elems;
      mode_d     = search_mode_t'(mode);
      signed_d   = signed_mode;
      thresh_d   = threshold;
      i_d        = '0;
      best_len_d = '0;
      start_d    = '0;
      wmin_d     = '0;
      wmax_d     = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      n_q        <= '0;
      mode_q     <= SEARCH_CONSEC;
      signed_q   <= 1'b0;
      thresh_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      best_len_q <= '0;
      start_q    <= '0;
      wmin_q     <= '0;
      wmax_q     <= '0;
    end else begin
      n_q        <= n_d;
      mode_q     <= mode_d;
      signed_q   <= signed_d;
      thresh_q   <= thresh_d;
      i_q        <= i_d;
      j_q        <= j_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      best_len_q <= best_len_d;
      start_q    <= start_d;
      wmin_q     <= wmin_d;
      wmax_q     <= wmax_d;
    end
  end

  // Tag pipe tracks which j each returning RAM word belongs to.
  always_ff @(posedge clock) begin
    // NOTE: the tag pipe is reset so an aborted scan leaves no stale tag behind.
    if (!resetn) begin
      for (int k = 0; k < LAT; k++) begin
        tag_vld_q[k] <= 1'b0;
        tag_j_q[k]   <= '0;
      end
    end else begin
      tag_vld_q[0] <= (state_q == ST_SCAN);
      tag_j_q[0]   <= j_q;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_j_q[k]   <= tag_j_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_custom_range_search_unit.sv
// Directed bench: two units (read latency 1 and 2) share a RAM image and are
// started together; results and finish timing are compared to hand values.
module tb_custom_range_search_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic              signed_mode = 1'b0;
  logic [ADDR_W:0]   num_elems = '0;
  logic [DATA_W-1:0] threshold = '0;

  logic [DATA_W-1:0] read_data, read_data2;
  logic [ADDR_W-1:0] address, address2, start_pos, start_pos2;
  logic              write_enable, write_enable2, busy, busy2, finish, finish2;
  logic [ADDR_W:0]   length, length2;
  logic [DATA_W-1:0] win_min, win_max, win_min2, win_max2;

  logic [DATA_W-1:0] mem [512];
  logic [DATA_W-1:0] vec [8];
  logic [DATA_W-1:0] rd1_q, rd2a_q, rd2b_q;

  int checks = 0;
  int errors = 0;
  int cyc1, cyc2;

  custom_range_search_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clock(clock), .resetn(resetn), .start(start), .num_elems(num_elems),
    .mode(mode), .signed_mode(signed_mode), .threshold(threshold),
    .read_data(read_data), .address(address), .write_enable(write_enable),
    .busy(busy), .finish(finish), .start_pos(start_pos), .length(length),
    .win_min(win_min), .win_max(win_max)
  );

  custom_range_search_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (
    .clock(clock), .resetn(resetn), .start(start), .num_elems(num_elems),
    .mode(mode), .signed_mode(signed_mode), .threshold(threshold),
    .read_data(read_data2), .address(address2), .write_enable(write_enable2),
    .busy(busy2), .finish(finish2), .start_pos(start_pos2), .length(length2),
    .win_min(win_min2), .win_max(win_max2)
  );

  always #5 clock = ~clock;

  // RAM model: latency 1 for dut, latency 2 for dut2.
  always @(posedge clock) begin
    rd1_q  <= mem[address];
    rd2a_q <= mem[address2];
    rd2b_q <= rd2a_q;
  end
  assign read_data  = rd1_q;
  assign read_data2 = rd2b_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_vec();
    for (int k = 0; k < 8; k++) mem[k] = vec[k];
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".address"},   32'(address),      0);
    check({tag, ".busy"},      32'(busy),         0);
    check({tag, ".finish"},    32'(finish),       0);
    check({tag, ".start_pos"}, 32'(start_pos),    0);
    check({tag, ".length"},    32'(length),       0);
    check({tag, ".win_min"},   32'(win_min),      0);
    check({tag, ".win_max"},   32'(win_max),      0);
    check({tag, ".wr_en"},     32'(write_enable), 0);
  endtask

  // Accept at edge 0; cyc1/cyc2 = edge at which each finish is first seen.
  task automatic run(input logic [ADDR_W:0] n, input logic md, input logic sg,
                     input logic [DATA_W-1:0] th, input int poke_at);
    @(negedge clock);
    num_elems = n; mode = md; signed_mode = sg; threshold = th; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc1 = 0; cyc2 = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clock); #1;
      start = (k == poke_at);
      if (k == poke_at) num_elems = '0;
      if (finish  && cyc1 == 0) cyc1 = k;
      if (finish2 && cyc2 == 0) cyc2 = k;
      if (cyc1 != 0 && cyc2 != 0) break;
    end
    start = 1'b0;
    check("finish_seen", 32'({cyc1 != 0, cyc2 != 0}), 32'h3);
  endtask

  task automatic expect_res(input string tag, input int sp, input int len,
                            input int wmin, input int wmax, input int cyc);
    check({tag, ".start_pos"}, 32'(start_pos), sp);
    check({tag, ".length"},    32'(length),    len);
    check({tag, ".win_min"},   32'(win_min),   wmin);
    check({tag, ".win_max"},   32'(win_max),   wmax);
    check({tag, ".cycles"},    cyc1,           cyc);
    check({tag, ".busy"},      32'(busy),      0);
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = '0;

    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    resetn = 1'b1;

    // Consecutive run, tie resolved to the earliest window.
    vec = '{16'd5, 16'd3, 16'd4, 16'd9, 16'd10, 16'd11, 16'd0, 16'd0};
    load_vec();
    run(10'd6, 1'b0, 1'b0, 16'd0, 0);
    expect_res("t1", 0, 3, 3, 5, 24);
    check("t1.lat2_length", 32'(length2), 3);
    check("t1.lat2_cycles", cyc2, 27);

    // Same data, signed vs unsigned compare.
    vec = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'd0, 16'd0, 16'd0, 16'd0};
    load_vec();
    run(10'd4, 1'b0, 1'b1, 16'd0, 0);
    expect_res("t2s", 0, 4, 32'hFFFE, 32'h0001, 7);
    run(10'd4, 1'b0, 1'b0, 16'd0, 0);
    expect_res("t2u", 1, 2, 0, 1, 13);

    // Threshold mode.
    vec = '{16'd10, 16'd12, 16'd11, 16'd20, 16'd21, 16'd22, 16'd23, 16'd0};
    load_vec();
    run(10'd7, 1'b1, 1'b0, 16'd2, 0);
    expect_res("t3", 0, 3, 10, 12, 34);

    // Early termination after row 0 and latency-dependent finish edge.
    vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    load_vec();
    run(10'd4, 1'b0, 1'b0, 16'd0, 0);
    expect_res("t4", 0, 4, 1, 4, 7);
    check("t4.lat2_cycles", cyc2, 8);
    check("t4.lat2_length", 32'(length2), 4);

    // Empty and single-element requests.
    run(10'd0, 1'b0, 1'b0, 16'd0, 0);
    expect_res("t5a", 0, 0, 0, 0, 1);
    check("t5a.finish", 32'(finish), 1);
    run(10'd1, 1'b0, 1'b0, 16'd0, 0);
    expect_res("t5b", 0, 1, 1, 1, 4);

    // Start pulsed (with a different count) while busy is ignored.
    vec = '{16'd5, 16'd3, 16'd4, 16'd9, 16'd10, 16'd11, 16'd0, 16'd0};
    load_vec();
    run(10'd6, 1'b0, 1'b0, 16'd0, 5);
    expect_res("t5c", 0, 3, 3, 5, 24);

    // Reset mid-SCAN aborts the run, then a clean re-run matches test 1.
    @(negedge clock);
    num_elems = 10'd6; mode = 1'b0; signed_mode = 1'b0; threshold = '0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("t6.busy_mid",   32'(busy),   1);
    check("t6.length_mid", 32'(length), 1);
    resetn = 1'b0;
    @(posedge clock); #1;
    check_idle("t6.reset");
    resetn = 1'b1;
    run(10'd6, 1'b0, 1'b0, 16'd0, 0);
    expect_res("t6", 0, 3, 3, 5, 24);
    check("t6.lat2_cycles", cyc2, 27);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
